coso_tune_ctrl: RTL and testbench
=================================

Name: coso_tune_ctrl

Overview:
Calibration and monitoring controller for the coherent-sampling (COSO) counter. It steps a ring-oscillator configuration word through its range and, at each setting, collects a block of beat run-length measurements. It locks onto the first setting whose average and spread fall inside programmed bounds, then watches live measurements and raises an alarm on sustained drift. Sits in the CLK_FF domain, directly downstream of the counter's run-length output and upstream of the oscillator tap-select logic.

Parameters:
CFG_W, 4, width of oscillator configuration word; search covers 0 .. 2^CFG_W-1
N_LOG2, 3, log2 of measurements averaged per setting (8)
SETTLE_CYCLES, 64, CLK_FF cycles to wait after each CFG change
TIMEOUT, 4096, max CLK_FF cycles between MEAS_VALID pulses before the setting is rejected
LO, 8, minimum acceptable run length (inclusive)
HI, 64, maximum acceptable run length (inclusive)
MAX_SPREAD, 16, maximum acceptable (max - min) within one block
ALARM_LIMIT, 4, consecutive out-of-window measurements in LOCKED that trigger ALARM

Ports:
CLK_FF  in  1  sampling clock; all logic in this domain
RST  in  1  synchronous, active-high reset
START  in  1  single-cycle request to begin or restart the search
MEAS_VALID  in  1  one-cycle strobe: MEAS holds a completed run length
MEAS  in  8  run length (255 = saturated)
CFG  out  CFG_W  oscillator configuration word
RING_EN  out  1  oscillator enable
BUSY  out  1  high while searching (SETTLE..NEXT)
LOCKED  out  1  high in LOCKED state
FAIL  out  1  high in FAIL state
ALARM  out  1  sticky drift flag
AVG  out  8  average of the last accepted block

Behaviour:
- Reset: state IDLE; CFG=0, RING_EN=0, BUSY=0, LOCKED=0, FAIL=0, ALARM=0, AVG=0; all counters and accumulators cleared. RST overrides every other input in every state.
- States: IDLE, SETTLE, DISCARD, MEASURE, EVAL, NEXT, LOCKED, FAIL.
- IDLE: START=1 -> SETTLE on the next cycle, with CFG=0, RING_EN=1, BUSY=1.
- SETTLE: counts SETTLE_CYCLES cycles, then -> DISCARD. MEAS_VALID is ignored.
- DISCARD: waits for one MEAS_VALID and drops it, because that run may be partial. Then -> MEASURE with sum, min and max cleared.
- MEASURE: each MEAS_VALID adds MEAS to sum (width 8+N_LOG2) and updates min and max. After the 2^N_LOG2-th strobe -> EVAL.
- Timeout: in DISCARD or MEASURE, a cycle counter resets on every MEAS_VALID. If it reaches TIMEOUT, go -> NEXT (setting rejected). This covers a dead or phase-locked ring.
- EVAL (one cycle): avg = sum >> N_LOG2. Accept when LO <= avg <= HI and (max - min) <= MAX_SPREAD.
  - Accept: AVG <= avg, go -> LOCKED.
  - Reject: go -> NEXT.
  - A saturated sample (255) is handled by the same arithmetic; no special case.
- NEXT (one cycle):
  - CFG == 2^CFG_W-1: go -> FAIL; CFG holds its value.
  - Otherwise: CFG <= CFG+1, go -> SETTLE.
- LOCKED: BUSY=0, LOCKED=1.
  - Each MEAS_VALID with MEAS < LO or MEAS > HI increments the bad counter; an in-window MEAS clears it.
  - When the bad counter reaches ALARM_LIMIT: set ALARM=1, clear the bad counter, go -> SETTLE with CFG=0 (automatic re-search).
- FAIL: FAIL=1, RING_EN=0, BUSY=0.
- START handling:
  - In LOCKED, FAIL or IDLE: restarts the search from CFG=0 and clears ALARM.
  - In SETTLE..NEXT: ignored.
  - In LOCKED, START wins over a simultaneous MEAS_VALID.
- MEAS_VALID is ignored in IDLE, SETTLE, EVAL, NEXT and FAIL.
- Latency: from START, the first acceptance is at least SETTLE_CYCLES + 2^N_LOG2 + 1 strobes + 2 cycles.

Decomposition:
- Package coso_tune_pkg: state enum type; localparam helpers for sum width (8+N_LOG2) and timeout counter width ($clog2(TIMEOUT+1)).
- Sub-module coso_meas_stats: clear/accumulate inputs; outputs sum, min, max. Keeps the controller FSM-only.

Test Plan:
- Reset mid-MEASURE at CFG=3 -> next cycle CFG=0, RING_EN=0, BUSY=0, all flags 0.
- START; CFG0 gives MEAS=4 (×9), CFG1 gives MEAS=20 (×9) -> CFG0 rejected, CFG1 locks; LOCKED=1, AVG=20, CFG=1.
- CFG0 samples alternate 10/40 (avg 25, spread 30) -> rejected on spread, CFG advances to 1.
- No MEAS_VALID for 4096 cycles at every CFG -> each setting times out; after CFG=15, FAIL=1, RING_EN=0, CFG=15.
- LOCKED at AVG=20, then MEAS=100 ×4 -> ALARM=1, state SETTLE, CFG=0. A pattern of 100,100,100,20,100 gives no alarm.
- START pulse during SETTLE -> ignored; the settle count continues uninterrupted.

Source files
------------

// File: rtl/coso_tune_pkg.sv
// rtl/coso_tune_pkg.sv - shared types and width helpers for the COSO tuning controller
package coso_tune_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DISCARD,
    ST_MEASURE,
    ST_EVAL,
    ST_NEXT,
    ST_LOCKED,
    ST_FAIL
  } state_e;

  function automatic int sum_width(input int n_log2);
    return 8 + n_log2;
  endfunction

  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/coso_meas_stats.sv
// rtl/coso_meas_stats.sv - running sum, minimum and maximum of one block of run lengths
module coso_meas_stats
  import coso_tune_pkg::*;
#(
  parameter int N_LOG2 = 3,
  localparam int SUM_W = sum_width(N_LOG2)
) (
  input  logic             clk_ff,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc,
  input  logic [7:0]       data,
  output logic [SUM_W-1:0] sum,
  output logic [7:0]       min_val,
  output logic [7:0]       max_val
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;

  always_ff @(posedge clk_ff) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // Clear seeds min high so the first accumulated sample sets both extremes.
  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (clr) begin
      sum_d = '0;
      min_d = 8'hff;
      max_d = 8'h00;
    end else if (acc) begin
      sum_d = sum_q + SUM_W'(data);
      if (data < min_q) min_d = data;
      if (data > max_q) max_d = data;
    end
  end

  assign sum     = sum_q;
  assign min_val = min_q;
  assign max_val = max_q;

endmodule

// File: rtl/coso_tune_ctrl.sv
// rtl/coso_tune_ctrl.sv - searches the ring configuration for a stable run length, then monitors drift
module coso_tune_ctrl
  import coso_tune_pkg::*;
#(
  parameter int CFG_W         = 4,
  parameter int N_LOG2        = 3,
  parameter int SETTLE_CYCLES = 64,
  parameter int TIMEOUT       = 4096,
  parameter int LO            = 8,
  parameter int HI            = 64,
  parameter int MAX_SPREAD    = 16,
  parameter int ALARM_LIMIT   = 4
) (
  input  logic             CLK_FF,
  input  logic             RST,
  input  logic             START,
  input  logic             MEAS_VALID,
  input  logic [7:0]       MEAS,
  output logic [CFG_W-1:0] CFG,
  output logic             RING_EN,
  output logic             BUSY,
  output logic             LOCKED,
  output logic             FAIL,
  output logic             ALARM,
  output logic [7:0]       AVG
);

  localparam int SUM_W = sum_width(N_LOG2);
  localparam int TMO_W = tmo_width(TIMEOUT);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (TMO_W > SET_W) ? TMO_W : SET_W;
  localparam int BAD_W = $clog2(ALARM_LIMIT + 1);

  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_END    = CNT_W'(TIMEOUT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST   = BAD_W'(ALARM_LIMIT - 1);
  localparam logic [N_LOG2-1:0] N_LAST     = '1;
  localparam logic [CFG_W-1:0]  CFG_LAST   = '1;
  localparam logic [7:0]        LO_V       = 8'(LO);
  localparam logic [7:0]        HI_V       = 8'(HI);
  localparam logic [7:0]        SPREAD_V   = 8'(MAX_SPREAD);

  state_e            state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_LOG2-1:0] n_q, n_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic              alarm_q, alarm_d;
  logic [7:0]        avg_q, avg_d;

  logic              stat_clr, stat_acc;
  logic [SUM_W-1:0]  stat_sum;
  logic [7:0]        stat_min, stat_max;
  logic [7:0]        blk_avg, blk_spread;
  logic              blk_accept, meas_out;

  coso_meas_stats #(.N_LOG2(N_LOG2)) u_stats (
    .clk_ff  (CLK_FF),
    .rst     (RST),
    .clr     (stat_clr),
    .acc     (stat_acc),
    .data    (MEAS),
    .sum     (stat_sum),
    .min_val (stat_min),
    .max_val (stat_max)
  );

  always_comb begin
    blk_avg    = 8'(stat_sum >> N_LOG2);
    blk_spread = stat_max - stat_min;
    blk_accept = (blk_avg >= LO_V) && (blk_avg <= HI_V) && (blk_spread <= SPREAD_V);
    meas_out   = (MEAS < LO_V) || (MEAS > HI_V);
  end

  always_ff @(posedge CLK_FF) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      bad_q   <= '0;
      alarm_q <= 1'b0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bad_q   <= bad_d;
      alarm_q <= alarm_d;
      avg_q   <= avg_d;
    end
  end

  // cnt_q doubles as the settle timer and the strobe-gap watchdog.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    bad_d    = bad_q;
    alarm_d  = alarm_q;
    avg_d    = avg_q;
    stat_clr = 1'b0;
    stat_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAIL: begin
        if (START) begin
          state_d = ST_SETTLE;
          cfg_d   = '0;
          cnt_d   = '0;
          alarm_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          state_d = ST_DISCARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DISCARD: begin
        if (MEAS_VALID) begin
          state_d  = ST_MEASURE;
          cnt_d    = '0;
          n_d      = '0;
          stat_clr = 1'b1;
        end else if (cnt_q == TMO_END) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (MEAS_VALID) begin
          stat_acc = 1'b1;
          cnt_d    = '0;
          n_d      = n_q + N_LOG2'(1);
          if (n_q == N_LAST) state_d = ST_EVAL;
        end else if (cnt_q == TMO_END) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (blk_accept) begin
          avg_d   = blk_avg;
          bad_d   = '0;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (cfg_q == CFG_LAST) begin
          state_d = ST_FAIL;
        end else begin
          cfg_d   = cfg_q + CFG_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_LOCKED: begin
        if (START) begin
          state_d = ST_SETTLE;
          cfg_d   = '0;
          cnt_d   = '0;
          alarm_d = 1'b0;
        end else if (MEAS_VALID) begin
          if (!meas_out) begin
            bad_d = '0;
          end else if (bad_q == BAD_LAST) begin
            alarm_d = 1'b1;
            bad_d   = '0;
            cfg_d   = '0;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY    = state_q inside {ST_SETTLE, ST_DISCARD, ST_MEASURE, ST_EVAL, ST_NEXT};
    LOCKED  = (state_q == ST_LOCKED);
    FAIL    = (state_q == ST_FAIL);
    RING_EN = (state_q != ST_IDLE) && (state_q != ST_FAIL);
  end

  assign CFG   = cfg_q;
  assign ALARM = alarm_q;
  assign AVG   = avg_q;

endmodule

// File: tb/tb_coso_tune_ctrl.sv
// tb/tb_coso_tune_ctrl.sv - directed bench with a cycle model of the tuning controller
module tb_coso_tune_ctrl;

  localparam int SETTLE = 64;
  localparam int TMO    = 4096;
  localparam int LO     = 8;
  localparam int HI     = 64;
  localparam int SPREAD = 16;
  localparam int ALIM   = 4;
  localparam int NBLK   = 8;
  localparam int CFGMAX = 15;

  localparam int M_IDLE = 0, M_SETTLE = 1, M_DISCARD = 2, M_MEASURE = 3,
                 M_EVAL = 4, M_NEXT = 5, M_LOCKED = 6, M_FAIL = 7;

  logic       CLK_FF = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       MEAS_VALID = 1'b0;
  logic [7:0] MEAS = 8'd0;
  logic [3:0] CFG;
  logic       RING_EN, BUSY, LOCKED, FAIL, ALARM;
  logic [7:0] AVG;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  coso_tune_ctrl dut (
    .CLK_FF     (CLK_FF),
    .RST        (RST),
    .START      (START),
    .MEAS_VALID (MEAS_VALID),
    .MEAS       (MEAS),
    .CFG        (CFG),
    .RING_EN    (RING_EN),
    .BUSY       (BUSY),
    .LOCKED     (LOCKED),
    .FAIL       (FAIL),
    .ALARM      (ALARM),
    .AVG        (AVG)
  );

  always #5 CLK_FF = ~CLK_FF;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number, sample list per block, plain arithmetic at evaluation.
  int m_ph, m_cfg, m_avg, m_wait, m_bad, m_alarm;
  int blk[$];
  int s, mn, mx, a;

  initial begin
    m_ph = M_IDLE; m_cfg = 0; m_avg = 0; m_wait = 0; m_bad = 0; m_alarm = 0;
    forever begin
      @(posedge CLK_FF);
      if (RST) begin
        m_ph = M_IDLE; m_cfg = 0; m_avg = 0; m_wait = 0; m_bad = 0; m_alarm = 0;
        blk.delete();
      end else begin
        case (m_ph)
          M_IDLE, M_FAIL: if (START) begin
            m_ph = M_SETTLE; m_cfg = 0; m_wait = 0; m_alarm = 0;
          end
          M_SETTLE: begin
            m_wait++;
            if (m_wait == SETTLE) begin m_ph = M_DISCARD; m_wait = 0; end
          end
          M_DISCARD, M_MEASURE: begin
            if (MEAS_VALID) begin
              m_wait = 0;
              if (m_ph == M_DISCARD) begin
                blk.delete();
                m_ph = M_MEASURE;
              end else begin
                blk.push_back(int'(MEAS));
                if (blk.size() == NBLK) m_ph = M_EVAL;
              end
            end else begin
              m_wait++;
              if (m_wait == TMO) m_ph = M_NEXT;
            end
          end
          M_EVAL: begin
            s = 0; mn = 255; mx = 0;
            foreach (blk[i]) begin
              s += blk[i];
              if (blk[i] < mn) mn = blk[i];
              if (blk[i] > mx) mx = blk[i];
            end
            a = s / NBLK;
            if (a >= LO && a <= HI && (mx - mn) <= SPREAD) begin
              m_avg = a; m_bad = 0; m_ph = M_LOCKED;
            end else begin
              m_ph = M_NEXT;
            end
          end
          M_NEXT: begin
            if (m_cfg == CFGMAX) m_ph = M_FAIL;
            else begin m_cfg++; m_wait = 0; m_ph = M_SETTLE; end
          end
          M_LOCKED: begin
            if (START) begin
              m_ph = M_SETTLE; m_cfg = 0; m_wait = 0; m_alarm = 0;
            end else if (MEAS_VALID) begin
              if (MEAS < LO || MEAS > HI) begin
                m_bad++;
                if (m_bad == ALIM) begin
                  m_alarm = 1; m_bad = 0; m_cfg = 0; m_wait = 0; m_ph = M_SETTLE;
                end
              end else begin
                m_bad = 0;
              end
            end
          end
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK_FF);
      if (chk_en) begin
        check("cfg", int'(CFG), m_cfg);
        check("ring_en", int'(RING_EN), int'(m_ph != M_IDLE && m_ph != M_FAIL));
        check("busy", int'(BUSY), int'(m_ph >= M_SETTLE && m_ph <= M_NEXT));
        check("locked", int'(LOCKED), int'(m_ph == M_LOCKED));
        check("fail", int'(FAIL), int'(m_ph == M_FAIL));
        check("alarm", int'(ALARM), m_alarm);
        check("avg", int'(AVG), m_avg);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_FF);
  endtask

  task automatic strobe(input logic [7:0] v);
    MEAS = v; MEAS_VALID = 1'b1;
    cyc(1);
    MEAS_VALID = 1'b0;
    cyc(2);
  endtask

  task automatic block9(input logic [7:0] v);
    for (int i = 0; i < 9; i++) strobe(v);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk_en = 1'b1;
    check("rst_cfg", int'(CFG), 0);
    check("rst_ring_en", int'(RING_EN), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_avg", int'(AVG), 0);
    RST = 1'b0;
    cyc(1);

    // Low block at CFG0 rejected, CFG1 locks at 20; strobe during settle is dropped.
    pulse_start();
    check("start_busy", int'(BUSY), 1);
    check("start_ring_en", int'(RING_EN), 1);
    strobe(8'd99);
    cyc(66);
    block9(8'd4);
    cyc(66);
    block9(8'd20);
    check("lock_locked", int'(LOCKED), 1);
    check("lock_avg", int'(AVG), 20);
    check("lock_cfg", int'(CFG), 1);
    check("model_avg", m_avg, 20);

    // Interrupted bad runs do not alarm; four in a row do.
    strobe(8'd100); strobe(8'd100); strobe(8'd100); strobe(8'd20);
    strobe(8'd100); strobe(8'd20);
    strobe(8'd100); strobe(8'd100); strobe(8'd100);
    check("noalarm_alarm", int'(ALARM), 0);
    check("noalarm_locked", int'(LOCKED), 1);
    strobe(8'd100);
    check("alarm_alarm", int'(ALARM), 1);
    check("alarm_busy", int'(BUSY), 1);
    check("alarm_cfg", int'(CFG), 0);
    check("model_alarm", m_alarm, 1);

    // START mid-settle must not restart the settle count: the first strobe lands right after settle ends.
    pulse_start();
    cyc(62);
    block9(8'd20);
    check("relock_locked", int'(LOCKED), 1);
    check("relock_alarm_sticky", int'(ALARM), 1);
    check("relock_cfg", int'(CFG), 0);

    // START beats a simultaneous strobe in LOCKED and clears ALARM.
    START = 1'b1; MEAS = 8'd100; MEAS_VALID = 1'b1;
    cyc(1);
    START = 1'b0; MEAS_VALID = 1'b0;
    check("restart_busy", int'(BUSY), 1);
    check("restart_alarm", int'(ALARM), 0);

    // Spread 30 rejected at CFG0.
    cyc(66);
    strobe(8'd10);
    for (int i = 0; i < 4; i++) begin strobe(8'd10); strobe(8'd40); end
    check("spread_cfg", int'(CFG), 1);
    check("spread_locked", int'(LOCKED), 0);

    // Saturated sample: avg 49 but spread 235, rejected at CFG1.
    cyc(66);
    strobe(8'd20);
    for (int i = 0; i < 7; i++) strobe(8'd20);
    strobe(8'd255);
    check("sat_cfg", int'(CFG), 2);
    cyc(66);
    block9(8'd4);
    check("adv_cfg", int'(CFG), 3);

    // Reset in the middle of MEASURE at CFG3.
    cyc(66);
    strobe(8'd20); strobe(8'd20); strobe(8'd20); strobe(8'd20);
    RST = 1'b1;
    cyc(1);
    check("mid_rst_cfg", int'(CFG), 0);
    check("mid_rst_ring_en", int'(RING_EN), 0);
    check("mid_rst_busy", int'(BUSY), 0);
    check("mid_rst_avg", int'(AVG), 0);
    check("mid_rst_flags", int'({LOCKED, FAIL, ALARM}), 0);
    RST = 1'b0;
    cyc(1);

    // Silent ring: every setting times out, then FAIL holding CFG15.
    pulse_start();
    for (int i = 0; i < 70000 && !FAIL; i++) cyc(1);
    cyc(1);
    check("to_fail", int'(FAIL), 1);
    check("to_ring_en", int'(RING_EN), 0);
    check("to_cfg", int'(CFG), 15);
    check("to_busy", int'(BUSY), 0);
    check("model_cfg", m_cfg, 15);

    pulse_start();
    check("fail_restart_busy", int'(BUSY), 1);
    check("fail_restart_cfg", int'(CFG), 0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
